// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front end: opcodes, FSM states and immediate decoders.
package fetch_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  // J-type immediate, sign-extended to 32 bits
  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended to 32 bits
  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode of a fetched word into a next-PC prediction.
// Backward branches are predicted taken only when FETCH_BTFN_PREDICT_EN is defined.
module fetch_predecode
  import fetch_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic        taken,
  output logic [31:0] target
);

`ifdef FETCH_BTFN_PREDICT_EN
  logic [31:0] b_imm_s;
  assign b_imm_s = imm_b(inst);
`else
  logic unused_b_bits_s;
  assign unused_b_bits_s = ^inst[11:7];
`endif

  // Opcode-based prediction; everything unrecognised falls through to pc+4
  always_comb begin
    taken  = 1'b0;
    target = pc + 32'd4;
    case (inst[6:0])
      OP_JAL: begin
        taken  = 1'b1;
        target = pc + imm_j(inst);
      end
      OP_BRANCH: begin
`ifdef FETCH_BTFN_PREDICT_EN
        if (b_imm_s[31]) begin
          taken  = 1'b1;
          target = pc + b_imm_s;
        end else begin
          taken  = 1'b0;
          target = pc + 32'd4;
        end
`else
        taken  = 1'b0;
        target = pc + 32'd4;
`endif
      end
      default: begin
        taken  = 1'b0;
        target = pc + 32'd4;
      end
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, single-outstanding imem request FSM and instruction-queue push.
// Optional backward-taken branch prediction via FETCH_BTFN_PREDICT_EN (see fetch_predecode).
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_iq_full,
  output logic        o_iq_wrt_en,
  output logic [31:0] o_iq_wrt_data,
  output logic [31:0] o_iq_wrt_inst_pc,
  output logic        o_iq_wrt_taken,
  output logic [31:0] o_iq_wrt_target
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  pc_r, pc_nxt_s;
  logic         req_valid_s;
  logic         accept_s;
  logic         push_s;
  logic         pd_taken_s;
  logic [31:0]  pd_target_s;
  logic [31:0]  next_pc_s;

  fetch_predecode u_predecode (
    .inst   (i_imem_rsp_data),
    .pc     (pc_r),
    .taken  (pd_taken_s),
    .target (pd_target_s)
  );

  assign req_valid_s = (state_r == S_REQ) & ~i_iq_full;
  assign accept_s    = req_valid_s & i_imem_req_ready;
  assign push_s      = i_imem_rsp_valid & (state_r == S_WAIT) & ~i_redirect;
  assign next_pc_s   = pd_taken_s ? pd_target_s : (pc_r + 32'd4);

  // Next-state and next-PC selection; redirect overrides normal sequencing
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    if (i_redirect) begin
      pc_nxt_s = i_redirect_pc;
      case (state_r)
        S_REQ:   state_nxt_s = accept_s ? S_DRAIN : S_REQ;
        S_WAIT:  state_nxt_s = i_imem_rsp_valid ? S_REQ : S_DRAIN;
        S_DRAIN: state_nxt_s = i_imem_rsp_valid ? S_REQ : S_DRAIN;
        default: state_nxt_s = S_REQ;
      endcase
    end else begin
      case (state_r)
        S_REQ: begin
          if (accept_s) begin
            state_nxt_s = S_WAIT;
          end else begin
            state_nxt_s = S_REQ;
          end
        end
        S_WAIT: begin
          if (i_imem_rsp_valid) begin
            state_nxt_s = S_REQ;
            pc_nxt_s    = next_pc_s;
          end else begin
            state_nxt_s = S_WAIT;
          end
        end
        S_DRAIN: begin
          if (i_imem_rsp_valid) begin
            state_nxt_s = S_REQ;
          end else begin
            state_nxt_s = S_DRAIN;
          end
        end
        default: state_nxt_s = S_REQ;
      endcase
    end
  end

  // State and PC registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_REQ;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  // Outputs are forced low while reset is asserted so nothing leaks during reset
  assign o_imem_req_valid = rstn & req_valid_s;
  assign o_imem_addr      = rstn ? {pc_r[31:2], 2'b00} : 32'h0000_0000;
  assign o_iq_wrt_en      = rstn & push_s;
  assign o_iq_wrt_data    = o_iq_wrt_en ? i_imem_rsp_data : 32'h0000_0000;
  assign o_iq_wrt_inst_pc = o_iq_wrt_en ? pc_r : 32'h0000_0000;
  assign o_iq_wrt_taken   = o_iq_wrt_en & pd_taken_s;
  assign o_iq_wrt_target  = o_iq_wrt_en ? pd_target_s : 32'h0000_0000;

endmodule
